// File: rtl/axis_ad9361_dual_if.sv
// AXI-Stream slave bundle feeding the dual AD9361 transmit buffer.
// The master modport belongs to the sample source; the slave modport belongs to the buffer.
interface axis_ad9361_dual_if #(
  parameter int PRECISION = 12
);
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic [8*PRECISION-1:0] s_axis_tdata;
  logic                   s_axis_tlast;

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/axis_ad9361_dual.sv
// Buffers 8-lane AXIS beats and plays them out to the DAC one set per dac_req,
// priming before playout and dropping back to idle on underflow.
module axis_ad9361_dual #(
  parameter int PRECISION         = 12,
  parameter int REVERSE_DATA      = 0,
  parameter int USE_AXIS_TLAST    = 0,
  parameter int AXIS_BURST_LENGTH = 512,
  parameter int BUFFER_DEPTH      = 4,
  parameter int PRIME_LEVEL       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  axis_ad9361_dual_if.slave        s_axis,
  input  logic                     dac_req,
  output logic                     dac_valid,
  output logic [11:0]              dac_data_i0,
  output logic [11:0]              dac_data_q0,
  output logic [11:0]              dac_data_i1,
  output logic [11:0]              dac_data_q1,
  output logic [11:0]              dac_data_i2,
  output logic [11:0]              dac_data_q2,
  output logic [11:0]              dac_data_i3,
  output logic [11:0]              dac_data_q3,
  output logic                     underflow,
  output logic [15:0]              underflow_count,
  output logic                     tlast_error
);
  localparam int W     = 8 * PRECISION;
  localparam int AW    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW    = $clog2(BUFFER_DEPTH + 1);
  localparam int SHIFT = 12 - PRECISION;

  // IDLE | priming, no pops, outputs zeroed ; RUN | one pop per dac_req
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [W-1:0]  mem_q [BUFFER_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic          full, empty, ready, push, pop, uf_evt;
  logic [W-1:0]  rd_word;
  logic [11:0]   mapped [8];
  logic          dac_valid_q;
  logic [11:0]   out_q [8];
  logic          underflow_q;
  logic [15:0]   uf_count_q;

  assign full    = (count_q == CW'(BUFFER_DEPTH));
  assign empty   = (count_q == '0);
  assign ready   = ~rst & ~full;
  assign push    = s_axis.s_axis_tvalid & ready;
  assign pop     = (state_q == ST_RUN) & dac_req & ~empty;
  assign uf_evt  = (state_q == ST_RUN) & dac_req & empty;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign rd_word = mem_q[rd_ptr_q];

  assign s_axis.s_axis_tready = ready;

  // Output slot j is ordered i0,q0,i1,q1,i2,q2,i3,q3; narrow lanes are MSB-aligned.
  for (genvar j = 0; j < 8; j++) begin : g_lane
    localparam int SRC = (REVERSE_DATA != 0) ? j : 7 - j;
    assign mapped[j] = 12'(rd_word[SRC*PRECISION +: PRECISION]) << SHIFT;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (count_q >= CW'(PRIME_LEVEL)) state_d = ST_RUN;
      ST_RUN:  if (uf_evt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis.s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dac_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      uf_count_q  <= '0;
      for (int j = 0; j < 8; j++) out_q[j] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop) begin
        dac_valid_q <= 1'b1;
        for (int j = 0; j < 8; j++) out_q[j] <= mapped[j];
      end else if (state_q == ST_RUN && !uf_evt) begin
        dac_valid_q <= 1'b0;
      end else begin
        dac_valid_q <= 1'b0;
        for (int j = 0; j < 8; j++) out_q[j] <= '0;
      end
      if (uf_evt) begin
        underflow_q <= 1'b1;
        if (uf_count_q != 16'hFFFF) uf_count_q <= uf_count_q + 16'd1;
      end
    end
  end

  assign dac_valid       = dac_valid_q;
  assign dac_data_i0     = out_q[0];
  assign dac_data_q0     = out_q[1];
  assign dac_data_i1     = out_q[2];
  assign dac_data_q1     = out_q[3];
  assign dac_data_i2     = out_q[4];
  assign dac_data_q2     = out_q[5];
  assign dac_data_i3     = out_q[6];
  assign dac_data_q3     = out_q[7];
  assign underflow       = underflow_q;
  assign underflow_count = uf_count_q;

  if (USE_AXIS_TLAST != 0) begin : g_tlast
    localparam int BW = (AXIS_BURST_LENGTH > 1) ? $clog2(AXIS_BURST_LENGTH) : 1;
    logic [BW-1:0] beat_q;
    logic          err_q;
    logic          at_end;

    assign at_end = (beat_q == BW'(AXIS_BURST_LENGTH - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        beat_q <= '0;
        err_q  <= 1'b0;
      end else begin
        err_q <= push & (s_axis.s_axis_tlast != at_end);
        if (push) beat_q <= (s_axis.s_axis_tlast | at_end) ? '0 : beat_q + 1'b1;
      end
    end

    assign tlast_error = err_q;
  end else begin : g_no_tlast
    logic unused_tlast;
    assign unused_tlast = s_axis.s_axis_tlast;
    assign tlast_error  = 1'b0;
  end
endmodule

// File: tb/tb_axis_ad9361_dual.sv
// Bench for axis_ad9361_dual: DUT A uses defaults, DUT B uses 8-bit reversed lanes with burst checking.
module tb_axis_ad9361_dual;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_ad9361_dual_if #(.PRECISION(12)) ifa ();
  axis_ad9361_dual_if #(.PRECISION(8))  ifb ();

  logic        req_a = 1'b0, req_b = 1'b0;
  logic        va, vb, ufa, ufb, tlea, tleb;
  logic [15:0] ufca, ufcb;
  logic [11:0] da [8];
  logic [11:0] db [8];
  logic [95:0] obs_a, obs_b;

  assign obs_a = {da[7], da[6], da[5], da[4], da[3], da[2], da[1], da[0]};
  assign obs_b = {db[7], db[6], db[5], db[4], db[3], db[2], db[1], db[0]};

  axis_ad9361_dual dut_a (
    .clk(clk), .rst(rst), .s_axis(ifa), .dac_req(req_a), .dac_valid(va),
    .dac_data_i0(da[0]), .dac_data_q0(da[1]), .dac_data_i1(da[2]), .dac_data_q1(da[3]),
    .dac_data_i2(da[4]), .dac_data_q2(da[5]), .dac_data_i3(da[6]), .dac_data_q3(da[7]),
    .underflow(ufa), .underflow_count(ufca), .tlast_error(tlea)
  );

  axis_ad9361_dual #(
    .PRECISION(8), .REVERSE_DATA(1), .USE_AXIS_TLAST(1), .AXIS_BURST_LENGTH(4),
    .BUFFER_DEPTH(4), .PRIME_LEVEL(2)
  ) dut_b (
    .clk(clk), .rst(rst), .s_axis(ifb), .dac_req(req_b), .dac_valid(vb),
    .dac_data_i0(db[0]), .dac_data_q0(db[1]), .dac_data_i1(db[2]), .dac_data_q1(db[3]),
    .dac_data_i2(db[4]), .dac_data_q2(db[5]), .dac_data_i3(db[6]), .dac_data_q3(db[7]),
    .underflow(ufb), .underflow_count(ufcb), .tlast_error(tleb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of buffered beats per DUT plus playout status.
  logic [95:0] qa[$];
  logic [95:0] qb[$];
  bit          run_m [2];
  bit          uf_m  [2];
  int          ufc_m [2];
  bit          val_m [2];
  logic [11:0] dat_m [2][8];
  int          tlc_m;
  bit          tle_m;
  int          tl_pulses;
  int          tl_disagree;

  function automatic logic [11:0] lane_of(input logic [95:0] beat, input int prec,
                                          input bit rev, input int j);
    int src;
    logic [11:0] v;
    src = rev ? j : 7 - j;
    v = '0;
    for (int b = 0; b < prec; b++) v[12-prec+b] = beat[src*prec+b];
    return v;
  endfunction

  function automatic logic [95:0] exp_pack(input int d);
    logic [95:0] r;
    for (int j = 0; j < 8; j++) r[j*12 +: 12] = dat_m[d][j];
    return r;
  endfunction

  task automatic model_one(input int d, input bit v, input logic [95:0] data,
                           input bit last, input bit req);
    logic [95:0] q[$];
    logic [95:0] beat;
    int pre;
    bit exp_last;
    if (d == 0) q = qa; else q = qb;
    pre = q.size();
    if (run_m[d] && req) begin
      if (pre > 0) begin
        beat = q.pop_front();
        val_m[d] = 1'b1;
        for (int j = 0; j < 8; j++) dat_m[d][j] = lane_of(beat, (d == 0) ? 12 : 8, d == 1, j);
      end else begin
        uf_m[d] = 1'b1;
        if (ufc_m[d] < 65535) ufc_m[d]++;
        run_m[d] = 1'b0;
        val_m[d] = 1'b0;
        for (int j = 0; j < 8; j++) dat_m[d][j] = '0;
      end
    end else if (run_m[d]) begin
      val_m[d] = 1'b0;
    end else begin
      val_m[d] = 1'b0;
      for (int j = 0; j < 8; j++) dat_m[d][j] = '0;
      if (pre >= 2) run_m[d] = 1'b1;
    end
    if (v && pre < 4) begin
      q.push_back(data);
      if (d == 1) begin
        exp_last = (tlc_m == 3);
        tle_m = (last != exp_last);
        tlc_m = (last || exp_last) ? 0 : tlc_m + 1;
      end
    end else if (d == 1) begin
      tle_m = 1'b0;
    end
    if (d == 0) qa = q; else qb = q;
  endtask

  task automatic step();
    if (rst) begin
      qa.delete();
      qb.delete();
      for (int d = 0; d < 2; d++) begin
        run_m[d] = 0; uf_m[d] = 0; ufc_m[d] = 0; val_m[d] = 0;
        for (int j = 0; j < 8; j++) dat_m[d][j] = '0;
      end
      tlc_m = 0;
      tle_m = 0;
    end else begin
      model_one(0, ifa.s_axis_tvalid, ifa.s_axis_tdata, 1'b0, req_a);
      model_one(1, ifb.s_axis_tvalid, {32'b0, ifb.s_axis_tdata}, ifb.s_axis_tlast, req_b);
    end
    @(posedge clk);
    #1;
    if (tleb) tl_pulses++;
    if (tleb !== tle_m) tl_disagree++;
  endtask

  task automatic idle_inputs();
    ifa.s_axis_tvalid = 0; ifa.s_axis_tdata = '0; ifa.s_axis_tlast = 0;
    ifb.s_axis_tvalid = 0; ifb.s_axis_tdata = '0; ifb.s_axis_tlast = 0;
    req_a = 0; req_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic push_b(input logic [63:0] data, input bit last);
    int n = 0;
    bit accepted = 0;
    ifb.s_axis_tvalid = 1; ifb.s_axis_tdata = data; ifb.s_axis_tlast = last;
    while (!accepted && n < 20) begin
      accepted = (qb.size() < 4);
      step();
      n++;
    end
    ifb.s_axis_tvalid = 0; ifb.s_axis_tlast = 0;
    total++;
    if (!accepted) begin bad++; $display("FAIL push_b_timeout got=%0d cycles want<20", n); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    total++;
    if ({ifa.s_axis_tready, ifb.s_axis_tready, va, vb} !== 4'b0000) begin
      bad++; $display("FAIL reset_ready_valid got=%b want=0000", {ifa.s_axis_tready, ifb.s_axis_tready, va, vb});
    end
    total++;
    if ({obs_a, obs_b, ufa, ufca, tleb} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h/%h uf=%b cnt=%h tle=%b want all 0", obs_a, obs_b, ufa, ufca, tleb);
    end
    rst = 0;
    step();
    total++;
    if ({ifa.s_axis_tready, ifb.s_axis_tready} !== 2'b11) begin
      bad++; $display("FAIL reset_release_ready got=%b want=11", {ifa.s_axis_tready, ifb.s_axis_tready});
    end
  endtask

  task automatic test_prime();
    logic [95:0] beat;
    for (int k = 0; k < 8; k++) beat[k*12 +: 12] = 12'(k + 1);
    ifa.s_axis_tvalid = 1; ifa.s_axis_tdata = beat; req_a = 1;
    step();
    total++;
    if (va !== 1'b0) begin bad++; $display("FAIL prime_idle_req got=%b want=0", va); end
    req_a = 0;
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom};
    step();
    ifa.s_axis_tvalid = 0;
    step();
    req_a = 1;
    step();
    req_a = 0;
    total++;
    if ({va, obs_a} !== {1'b1, 96'h001002003004005006007008}) begin
      bad++; $display("FAIL prime_first_out got=%b %h want=1 001002003004005006007008", va, obs_a);
    end
    total++;
    if (obs_a !== exp_pack(0)) begin bad++; $display("FAIL prime_model got=%h want=%h", obs_a, exp_pack(0)); end
    step();
    total++;
    if ({va, obs_a} !== {1'b0, 96'h001002003004005006007008}) begin
      bad++; $display("FAIL prime_hold got=%b %h want=0 001002003004005006007008", va, obs_a);
    end
  endtask

  task automatic test_lanes_b();
    logic [63:0] beat;
    do_reset();
    beat = {$urandom, $urandom};
    beat[7:0] = 8'h80;
    beat[63:56] = 8'h7F;
    ifb.s_axis_tvalid = 1; ifb.s_axis_tdata = beat;
    step();
    ifb.s_axis_tdata = {$urandom, $urandom};
    step();
    ifb.s_axis_tvalid = 0;
    step();
    req_b = 1;
    step();
    req_b = 0;
    total++;
    if ({vb, db[0], db[7]} !== {1'b1, 12'h800, 12'h7F0}) begin
      bad++; $display("FAIL lanes_b got=%b i0=%h q3=%h want=1 800 7F0", vb, db[0], db[7]);
    end
    total++;
    if (obs_b !== exp_pack(1)) begin bad++; $display("FAIL lanes_b_model got=%h want=%h", obs_b, exp_pack(1)); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ifa.s_axis_tvalid = 1; ifa.s_axis_tdata = {$urandom, $urandom, $urandom};
      step();
      if (k == 2) begin
        total++;
        if (ifa.s_axis_tready !== 1'b1) begin bad++; $display("FAIL full_ready_3 got=%b want=1", ifa.s_axis_tready); end
      end
    end
    ifa.s_axis_tvalid = 0;
    total++;
    if (ifa.s_axis_tready !== 1'b0) begin bad++; $display("FAIL full_ready_4 got=%b want=0", ifa.s_axis_tready); end
    req_a = 1;
    step();
    req_a = 0;
    total++;
    if ({ifa.s_axis_tready, va} !== 2'b11) begin
      bad++; $display("FAIL full_pop_ready got=%b want=11", {ifa.s_axis_tready, va});
    end
    total++;
    if (obs_a !== exp_pack(0)) begin bad++; $display("FAIL full_pop_data got=%h want=%h", obs_a, exp_pack(0)); end
  endtask

  task automatic test_random_stream();
    int acc = 0;
    int cyc = 0;
    int errs = 0;
    while (acc < 100 && cyc < 3000) begin
      ifa.s_axis_tvalid = ($urandom_range(0, 3) != 0);
      ifa.s_axis_tdata  = {$urandom, $urandom, $urandom};
      req_a = ($urandom_range(0, 1) != 0);
      if (ifa.s_axis_tvalid && qa.size() < 4) acc++;
      step();
      cyc++;
      total++;
      if ({ifa.s_axis_tready, va, obs_a, ufa, ufca} !==
          {qa.size() < 4, val_m[0], exp_pack(0), uf_m[0], 16'(ufc_m[0])}) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random_cycle%0d got=%b %b %h %b %0d want=%b %b %h %b %0d", cyc,
                   ifa.s_axis_tready, va, obs_a, ufa, ufca,
                   qa.size() < 4, val_m[0], exp_pack(0), uf_m[0], ufc_m[0]);
      end
    end
    idle_inputs();
    total++;
    if (acc < 100) begin bad++; $display("FAIL random_accept_budget got=%0d want=100", acc); end
  endtask

  task automatic test_underflow();
    do_reset();
    ifa.s_axis_tvalid = 1;
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom}; step();
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom}; step();
    ifa.s_axis_tvalid = 0;
    step();
    req_a = 1;
    step();
    step();
    step();
    total++;
    if ({ufa, ufca, va, obs_a} !== {1'b1, 16'd1, 1'b0, 96'd0}) begin
      bad++; $display("FAIL underflow_event got=%b %0d %b %h want=1 1 0 0", ufa, ufca, va, obs_a);
    end
    step();
    total++;
    if ({va, ufca} !== {1'b0, 16'd1}) begin
      bad++; $display("FAIL underflow_idle_req got=%b %0d want=0 1", va, ufca);
    end
    req_a = 0;
    ifa.s_axis_tvalid = 1;
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom}; step();
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom}; step();
    ifa.s_axis_tvalid = 0;
    step();
    req_a = 1;
    step();
    req_a = 0;
    total++;
    if ({va, ufa, ufca} !== {1'b1, 1'b1, 16'd1}) begin
      bad++; $display("FAIL underflow_resume got=%b %b %0d want=1 1 1", va, ufa, ufca);
    end
    total++;
    if (obs_a !== exp_pack(0)) begin bad++; $display("FAIL underflow_resume_data got=%h want=%h", obs_a, exp_pack(0)); end
  endtask

  task automatic test_tlast();
    do_reset();
    req_b = 1;
    tl_pulses = 0; tl_disagree = 0;
    push_b({$urandom, $urandom}, 0);
    push_b({$urandom, $urandom}, 0);
    push_b({$urandom, $urandom}, 1);
    step();
    total++;
    if (tl_pulses !== 1) begin bad++; $display("FAIL tlast_early got=%0d pulses want=1", tl_pulses); end
    tl_pulses = 0;
    for (int k = 0; k < 4; k++) push_b({$urandom, $urandom}, k == 3);
    step();
    total++;
    if (tl_pulses !== 0) begin bad++; $display("FAIL tlast_good got=%0d pulses want=0", tl_pulses); end
    tl_pulses = 0;
    for (int k = 0; k < 4; k++) push_b({$urandom, $urandom}, 0);
    step();
    total++;
    if (tl_pulses !== 1) begin bad++; $display("FAIL tlast_missing got=%0d pulses want=1", tl_pulses); end
    total++;
    if (tl_disagree !== 0) begin bad++; $display("FAIL tlast_model got=%0d disagreements want=0", tl_disagree); end
    total++;
    if (tlea !== 1'b0) begin bad++; $display("FAIL tlast_disabled got=%b want=0", tlea); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    ifa.s_axis_tvalid = 1;
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom}; step();
    ifa.s_axis_tdata = {$urandom, $urandom, $urandom}; step();
    ifa.s_axis_tvalid = 0;
    step();
    req_a = 1;
    step(); step(); step();
    req_a = 0;
    ifa.s_axis_tvalid = 1;
    for (int k = 0; k < 3; k++) begin
      ifa.s_axis_tdata = {$urandom, $urandom, $urandom};
      step();
    end
    ifa.s_axis_tvalid = 0;
    step();
    total++;
    if ({ufa, run_m[0], qa.size() == 3} !== 3'b111) begin
      bad++; $display("FAIL midrun_setup got uf=%b run=%b size=%0d want 1 1 3", ufa, run_m[0], qa.size());
    end
    rst = 1;
    step();
    total++;
    if ({ifa.s_axis_tready, va, obs_a, ufa, ufca, tleb} !== '0) begin
      bad++; $display("FAIL midrun_reset got rdy=%b v=%b d=%h uf=%b cnt=%0d tle=%b want all 0",
                      ifa.s_axis_tready, va, obs_a, ufa, ufca, tleb);
    end
    rst = 0;
    step();
    total++;
    if (ifa.s_axis_tready !== 1'b1) begin bad++; $display("FAIL midrun_release got=%b want=1", ifa.s_axis_tready); end
    req_a = 1;
    step();
    step();
    req_a = 0;
    total++;
    if (va !== 1'b0) begin bad++; $display("FAIL midrun_req_after got=%b want=0", va); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_prime();
    test_lanes_b();
    test_full();
    test_random_stream();
    test_underflow();
    test_tlast();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
